// File: rtl/ps2_key_sequencer_pkg.sv
// Shared definitions for the PS/2 key sequencer: scan-code set 2 bytes,
// key bit positions in the held bitmap, and sequencer state encodings.
package ps2_key_defs;

  // Prefix bytes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  // Non-extended key codes
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_B     = 8'h32;
  localparam logic [7:0] SC_C     = 8'h21;
  localparam logic [7:0] SC_D     = 8'h23;

  // Extended key codes (only valid after E0)
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Key indices, equal to the bit position in key_held
  localparam logic [2:0] KEY_A     = 3'd0;
  localparam logic [2:0] KEY_B     = 3'd1;
  localparam logic [2:0] KEY_C     = 3'd2;
  localparam logic [2:0] KEY_D     = 3'd3;
  localparam logic [2:0] KEY_UP    = 3'd4;
  localparam logic [2:0] KEY_DOWN  = 3'd5;
  localparam logic [2:0] KEY_LEFT  = 3'd6;
  localparam logic [2:0] KEY_RIGHT = 3'd7;

  // Sequencer states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

endpackage

// File: rtl/ps2_key_lookup.sv
// Maps a scan-code byte to one of the eight tracked keys. The extended flag
// selects which code table applies, so a code from the wrong table misses.
module ps2_key_lookup
  import ps2_key_defs::*;
(
  input  logic [7:0] code,
  input  logic       ext,
  output logic       hit,
  output logic [2:0] idx
);

  // Table lookup, split by extended flag
  always_comb begin
    hit = 1'b0;
    idx = 3'd0;
    if (ext) begin
      case (code)
        SC_UP:    begin hit = 1'b1; idx = KEY_UP;    end
        SC_DOWN:  begin hit = 1'b1; idx = KEY_DOWN;  end
        SC_LEFT:  begin hit = 1'b1; idx = KEY_LEFT;  end
        SC_RIGHT: begin hit = 1'b1; idx = KEY_RIGHT; end
        default:  begin hit = 1'b0; idx = 3'd0;      end
      endcase
    end else begin
      case (code)
        SC_A:     begin hit = 1'b1; idx = KEY_A; end
        SC_B:     begin hit = 1'b1; idx = KEY_B; end
        SC_C:     begin hit = 1'b1; idx = KEY_C; end
        SC_D:     begin hit = 1'b1; idx = KEY_D; end
        default:  begin hit = 1'b0; idx = 3'd0;  end
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code set 2 sequencer for eight keys.
//
// state      | meaning
// -----------+------------------------------------------------
// IDLE       | no prefix seen, next byte is make/prefix
// EXT        | E0 seen, expecting extended make or F0
// BRK        | F0 seen, expecting non-extended break code
// EXT_BRK    | E0 F0 seen, expecting extended break code
//
// Bytes are only consumed while no event is pending; a byte arriving with an
// event outstanding is dropped and flagged. Prefix states time out back to IDLE.
module ps2_key_sequencer
  import ps2_key_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int TO_W           = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       rx_en,
  output logic [7:0] key_held,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_key,
  output logic       evt_press,
  output logic       seq_error
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [TO_W-1:0] to_cnt;

  logic       accepted;
  logic       dropped;
  logic       timeout_hit;
  logic       lk_ext;
  logic       lk_hit;
  logic [2:0] lk_idx;
  logic       do_make;
  logic       do_break;
  logic       load_press;
  logic       load_release;
  logic       evt_valid_nxt;
  logic       seq_error_nxt;

  assign accepted    = rx_done_tick & ~evt_valid;
  assign dropped     = rx_done_tick & evt_valid;
  assign timeout_hit = (state != ST_IDLE) && (to_cnt == TO_LAST);
  assign lk_ext      = (state == ST_EXT) || (state == ST_EXT_BRK);

  ps2_key_lookup u_lookup (
    .code (rx_data),
    .ext  (lk_ext),
    .hit  (lk_hit),
    .idx  (lk_idx)
  );

  // Next-state and make/break decode; an accepted byte takes priority over timeout
  always_comb begin
    state_nxt = state;
    do_make   = 1'b0;
    do_break  = 1'b0;
    if (accepted) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == SC_EXT)      state_nxt = ST_EXT;
          else if (rx_data == SC_BRK) state_nxt = ST_BRK;
          else begin
            state_nxt = ST_IDLE;
            do_make   = lk_hit;
          end
        end
        ST_EXT: begin
          if (rx_data == SC_BRK) state_nxt = ST_EXT_BRK;
          else begin
            state_nxt = ST_IDLE;
            do_make   = lk_hit;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          do_break  = lk_hit;
        end
      endcase
    end else if (timeout_hit) begin
      state_nxt = ST_IDLE;
    end
  end

  // Typematic repeats and breaks of unheld keys produce no event
  assign load_press    = do_make  & ~key_held[lk_idx];
  assign load_release  = do_break &  key_held[lk_idx];
  assign evt_valid_nxt = load_press | load_release | (evt_valid & ~evt_ready);
  assign seq_error_nxt = dropped | (timeout_hit & ~accepted);

  // State, timeout counter, bitmap, event register and receiver gating
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      to_cnt    <= '0;
      key_held  <= 8'h00;
      evt_valid <= 1'b0;
      evt_key   <= 3'd0;
      evt_press <= 1'b0;
      seq_error <= 1'b0;
      rx_en     <= 1'b0;
    end else begin
      state     <= state_nxt;
      seq_error <= seq_error_nxt;
      evt_valid <= evt_valid_nxt;
      rx_en     <= ~evt_valid_nxt;

      if (accepted || timeout_hit || (state == ST_IDLE)) to_cnt <= '0;
      else                                             to_cnt <= to_cnt + 1'b1;

      if (load_press) begin
        key_held[lk_idx] <= 1'b1;
        evt_key          <= lk_idx;
        evt_press        <= 1'b1;
      end else if (load_release) begin
        key_held[lk_idx] <= 1'b0;
        evt_key          <= lk_idx;
        evt_press        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Self-checking bench for ps2_key_sequencer: directed scenarios followed by
// random byte/ack/reset traffic, all compared against a prefix-flag model.
module tb_ps2_key_sequencer;

  localparam int TC = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       rx_en;
  logic [7:0] key_held;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_key;
  logic       evt_press;
  logic       seq_error;

  int tests = 0;
  int fails = 0;

  // Reference model: pending-prefix flags, held array, single event slot
  bit       m_ext, m_brk;
  bit [7:0] m_held;
  bit       m_valid, m_press, m_err, m_rxen;
  bit [2:0] m_key;
  int       cyc = 0;
  int       last_acc = 0;

  ps2_key_sequencer #(.TIMEOUT_CYCLES(TC), .TO_W(22)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .rx_en        (rx_en),
    .key_held     (key_held),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_key      (evt_key),
    .evt_press    (evt_press),
    .seq_error    (seq_error)
  );

  always #5 clk = ~clk;

  function automatic int find_key(logic [7:0] b, bit ext);
    logic [7:0] codes [8];
    codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74};
    for (int i = 0; i < 4; i++) begin
      if (codes[ext ? i + 4 : i] == b) return ext ? i + 4 : i;
    end
    return -1;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_byte(logic [7:0] d);
    int k;
    if (m_brk) begin
      k = find_key(d, m_ext);
      if (k >= 0 && m_held[k]) begin
        m_held[k] = 1'b0; m_valid = 1'b1; m_key = 3'(k); m_press = 1'b0;
      end
      m_ext = 1'b0; m_brk = 1'b0;
    end else if (m_ext) begin
      if (d == 8'hF0) m_brk = 1'b1;
      else begin
        k = find_key(d, 1'b1);
        if (k >= 0 && !m_held[k]) begin
          m_held[k] = 1'b1; m_valid = 1'b1; m_key = 3'(k); m_press = 1'b1;
        end
        m_ext = 1'b0;
      end
    end else if (d == 8'hE0) m_ext = 1'b1;
    else if (d == 8'hF0) m_brk = 1'b1;
    else begin
      k = find_key(d, 1'b0);
      if (k >= 0 && !m_held[k]) begin
        m_held[k] = 1'b1; m_valid = 1'b1; m_key = 3'(k); m_press = 1'b1;
      end
    end
  endtask

  task automatic model_edge(bit rst, bit tick, logic [7:0] d, bit rdy);
    bit pv;
    cyc++;
    if (rst) begin
      m_ext = 0; m_brk = 0; m_held = 0; m_valid = 0; m_key = 0;
      m_press = 0; m_err = 0; m_rxen = 0;
      return;
    end
    pv    = m_valid;
    m_err = 1'b0;
    if (rdy && pv) m_valid = 1'b0;
    if (tick && pv) m_err = 1'b1;
    if (tick && !pv) begin
      last_acc = cyc;
      model_byte(d);
    end else if ((m_ext || m_brk) && cyc == last_acc + TC) begin
      m_ext = 1'b0; m_brk = 1'b0; m_err = 1'b1;
    end
    m_rxen = !m_valid;
  endtask

  task automatic step(bit rst, bit tick, logic [7:0] d, bit rdy);
    reset = rst; rx_done_tick = tick; rx_data = d; evt_ready = rdy;
    @(posedge clk);
    model_edge(rst, tick, d, rdy);
    #1;
    check("evt_valid", 32'(evt_valid), 32'(m_valid));
    check("key_held",  32'(key_held),  32'(m_held));
    check("seq_error", 32'(seq_error), 32'(m_err));
    check("rx_en",     32'(rx_en),     32'(m_rxen));
    check("evt_key",   32'(evt_key),   32'(m_key));
    check("evt_press", 32'(evt_press), 32'(m_press));
    reset = 1'b0; rx_done_tick = 1'b0; evt_ready = 1'b0;
  endtask

  task automatic send(logic [7:0] b); step(0, 1, b, 0); endtask
  task automatic ack();               step(0, 0, 8'h00, 1); endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0);
  endtask

  initial begin
    int pulses;
    int r;
    logic [7:0] b;
    logic [7:0] pick [10];
    pick = '{8'hE0, 8'hF0, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74};
    reset = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00; evt_ready = 1'b0;

    // Reset state
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    check("reset_rx_en", 32'(rx_en), 32'd0);
    idle(2);

    // Simple make with latency 1, then acknowledge
    send(8'h1C);
    check("a_press_valid", 32'(evt_valid), 32'd1);
    check("a_press_key",   32'(key_held),  32'h01);
    check("a_press_rx_en", 32'(rx_en),     32'd0);
    idle(3);
    check("a_hold_valid", 32'(evt_valid), 32'd1);
    ack();
    check("a_ack_rx_en", 32'(rx_en), 32'd1);

    // Release a
    send(8'hF0); send(8'h1C); ack();
    check("a_release_held", 32'(key_held), 32'h00);

    // Extended up press and release
    send(8'hE0); send(8'h75);
    check("up_press_held", 32'(key_held), 32'h10);
    check("up_press_key",  32'(evt_key),  32'd4);
    ack(); idle(2);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("up_release_held", 32'(key_held), 32'h00);
    check("up_release_dir",  32'(evt_press), 32'd0);
    ack();

    // Typematic repeat: one press, one release
    send(8'h1C); ack(); send(8'h1C); send(8'h1C); idle(1);
    check("repeat_no_evt", 32'(evt_valid), 32'd0);
    send(8'hF0); send(8'h1C);
    check("repeat_release", 32'(evt_valid), 32'd1);
    ack();

    // Prefix timeout followed by bare extended code
    send(8'hE0);
    pulses = 0;
    for (int i = 1; i <= TC + 5; i++) begin
      step(0, 0, 8'h00, 0);
      if (seq_error) pulses++;
    end
    check("timeout_pulses", 32'(pulses), 32'd1);
    send(8'h75); idle(1);
    check("bare_ext_no_evt", 32'(evt_valid), 32'd0);

    // Dropped byte while event pending
    send(8'h23);
    send(8'h32);
    check("drop_err",  32'(seq_error), 32'd1);
    check("drop_held", 32'(key_held),  32'h08);
    ack(); idle(1);
    check("drop_no_evt", 32'(evt_valid), 32'd0);
    send(8'hF0); send(8'h23); ack();

    // Pending break prefix discarded by reset
    send(8'hF0);
    step(1, 0, 8'h00, 0);
    send(8'h1C);
    check("rst_prefix_press", 32'(evt_press), 32'd1);
    ack();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 1) step(1, 0, 8'h00, 0);
      else if (r < 3) idle(int'($urandom_range(TC - 3, TC + 3)));
      else if (r < 45) begin
        if ($urandom_range(0, 9) == 0) b = 8'($urandom);
        else b = pick[$urandom_range(0, 9)];
        step(0, 1, b, bit'($urandom_range(0, 1)));
      end else step(0, 0, 8'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
